ifetch_queue: RTL

Instruction fetch front-end placed directly upstream of the single-cycle core's decode stage. Owns the program counter, issues pipelined read requests to an instruction memory with variable, in-order response latency, and buffers returned words in a small FIFO. Presents one instruction plus its PC per cycle to the core under a valid/ready handshake, and supports redirect (flush) for branches and jumps.

---
 rtl/ifetch_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: owns the PC, keeps up to DEPTH fetches
// in flight and buffers in-order responses for the decode stage.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = CW + 2;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] occ;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [SW-1:0] used;

  logic grant;
  logic resp_drop;
  logic resp_push;
  logic resp_any;
  logic pop;

  // Credit covers buffered, in-flight and to-be-discarded words alike
  assign used = SW'(occ) + SW'(outst) + SW'(drop);

  assign mem_req_o  = !rst && !flush_i && (used < SW'(DEPTH));
  assign mem_addr_o = fetch_pc;

  assign grant     = mem_req_o && mem_gnt_i;
  assign resp_drop = mem_rvalid_i && (drop != '0);
  assign resp_push = mem_rvalid_i && (drop == '0) && (outst != '0);
  assign resp_any  = resp_drop || resp_push;

  assign inst_valid_o = (occ != '0);
  assign pop          = inst_valid_o && inst_ready_i;
  assign inst_o       = inst_valid_o ? inst_q[rd_ptr] : '0;
  assign inst_pc_o    = inst_valid_o ? pc_q[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      outst    <= '0;
      drop     <= '0;
    end else if (flush_i) begin
      fetch_pc <= flush_pc_i & ~32'h3;
      resp_pc  <= flush_pc_i & ~32'h3;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      outst    <= '0;
      // Every pending response becomes stale; one arriving now is consumed
      drop     <= drop + outst - CW'(resp_any);
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (resp_push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occ   <= occ + CW'(resp_push) - CW'(pop);
      outst <= outst + CW'(grant) - CW'(resp_push);
      drop  <= drop - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i && resp_push) begin
      inst_q[wr_ptr] <= mem_rdata_i;
      pc_q[wr_ptr]   <= resp_pc;
    end
  end

endmodule
